// File: rtl/multiplexer_pkg.sv
// Shared datapath constants and types for the multiplexer slice.
// The default data width here is the team-wide default for leaf datapath blocks.
package multiplexer_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 1;

  typedef enum logic {
    SEL_X = 1'b0,
    SEL_Y = 1'b1
  } sel_e;

endpackage

// File: rtl/multiplexer_mux2_cell.sv
// Single-bit 2:1 combinational cell; replicated per bit by the multiplexer top.
// AND-OR form keeps it a pure gate network with no priority logic and nothing to latch.
module mux2_cell (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic o
);

  assign o = (a & ~s) | (b & s);

endmodule

// File: rtl/multiplexer.sv
// Two-input data multiplexer with a zero-latency output z and a clk-retimed copy
// z_q, plus sel_q so downstream logic knows which source z_q carries.
module multiplexer
  import multiplexer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_q,
  output logic             sel_q
);

  // One cell per bit, all sharing the select; z never depends on clk or rst.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    mux2_cell u_cell (
      .a (x[i]),
      .b (y[i]),
      .s (sel),
      .o (z[i])
    );
  end

  // Retimed copies; reset only reaches the registers, never the outputs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q   <= '0;
      sel_q <= 1'b0;
    end else begin
      z_q   <= z;
      sel_q <= sel;
    end
  end

endmodule

// File: tb/tb_multiplexer.sv
// Self-checking bench for multiplexer: direct combinational checks with the clock
// stopped, then a queued scoreboard for the registered outputs under random streaming.
module tb_multiplexer;

  typedef struct packed {
    logic [7:0] zq8;
    logic       sq8;
    logic       zq1;
    logic       sq1;
  } exp_t;

  logic       clk = 1'b0;
  logic       clkEn = 1'b0;
  logic       rst;
  logic [7:0] x8, y8, z8, zq8;
  logic       sel8, sq8;
  logic       x1, y1, sel1, z1, zq1, sq1;

  int numCompared = 0;
  int numMismatched = 0;
  exp_t expQ[$];

  multiplexer #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .x     (x8),
    .y     (y8),
    .sel   (sel8),
    .z     (z8),
    .z_q   (zq8),
    .sel_q (sq8)
  );

  multiplexer #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .x     (x1),
    .y     (y1),
    .sel   (sel1),
    .z     (z1),
    .z_q   (zq1),
    .sel_q (sq1)
  );

  // Clock only toggles once the clock-free combinational phase is over.
  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  function automatic logic [7:0] refMux8(input logic [7:0] a, input logic [7:0] b, input logic s);
    return s ? b : a;
  endfunction

  function automatic logic refMux1(input logic a, input logic b, input logic s);
    return s ? b : a;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clocked transaction: drive away from the edge, queue what the edge must produce.
  task automatic applyStimulus(input logic r, input logic [7:0] a8, input logic [7:0] b8,
                               input logic s8, input logic a1, input logic b1, input logic s1);
    exp_t e;
    @(negedge clk);
    rst = r; x8 = a8; y8 = b8; sel8 = s8; x1 = a1; y1 = b1; sel1 = s1;
    e.zq8 = r ? 8'h00 : refMux8(a8, b8, s8);
    e.sq8 = r ? 1'b0 : s8;
    e.zq1 = r ? 1'b0 : refMux1(a1, b1, s1);
    e.sq1 = r ? 1'b0 : s1;
    expQ.push_back(e);
    #1;
    checkOutput("z8_comb", z8, refMux8(a8, b8, s8));
    @(posedge clk);
  endtask

  // Monitor: every edge that had a transaction queued is checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("z_q8", zq8, e.zq8);
        checkOutput("sel_q8", {7'b0, sq8}, {7'b0, e.sq8});
        checkOutput("z_q1", {7'b0, zq1}, {7'b0, e.zq1});
        checkOutput("sel_q1", {7'b0, sq1}, {7'b0, e.sq1});
      end
    end
  end

  initial begin
    logic [2:0] combo;
    logic [7:0] rx, ry;
    logic       rs, rr;
    int         waitCycles;

    rst = 1'b1;
    x8 = 8'h00; y8 = 8'h00; sel8 = 1'b0;
    x1 = 1'b0; y1 = 1'b0; sel1 = 1'b0;

    // Clock stopped: stepped WIDTH=1 sequence.
    #10 checkOutput("step0", {7'b0, z1}, 8'h00);
    x1 = 1'b1;   #10 checkOutput("step1", {7'b0, z1}, 8'h01);
    y1 = 1'b1;   #10 checkOutput("step2", {7'b0, z1}, 8'h01);
    sel1 = 1'b1; #10 checkOutput("step3", {7'b0, z1}, 8'h01);
    x1 = 1'b0;   #10 checkOutput("step4", {7'b0, z1}, 8'h01);

    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      x1 = combo[0]; y1 = combo[1]; sel1 = combo[2];
      #10 checkOutput("exhaustive1", {7'b0, z1}, {7'b0, refMux1(combo[0], combo[1], combo[2])});
    end

    x8 = 8'hA5; y8 = 8'h3C; sel8 = 1'b0;
    #10 checkOutput("iso_sel0", z8, 8'hA5);
    sel8 = 1'b1;
    #10 checkOutput("iso_sel1", z8, 8'h3C);
    x8 = 8'hFF;
    #10 checkOutput("iso_xchange", z8, 8'h3C);

    $display("[TB] starting clock");
    clkEn = 1'b1;

    // Reset held for two edges, then first capture after release.
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Alternating select, then a single-edge reset in the middle of the stream.
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 8'h11, 8'h22, 1'(i % 2), 1'b0, 1'b1, 1'(i % 2));
    applyStimulus(1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random streaming with occasional reset.
    for (int i = 0; i < 200; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rs = 1'($urandom);
      rr = ($urandom_range(0, 15) == 0);
      applyStimulus(rr, rx, ry, rs, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    checkOutput("queue_drained", 8'(expQ.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
